requant_pipe: RTL and testbench

- Output quantisation stage directly downstream of the per-lane 32-bit accumulator.
- Takes LANES signed accumulator sums, adds a per-output-channel bias, and scales by a fixed-point multiplier.
- Performs a rounding right shift, adds the output zero point, then saturates to unsigned OUT_W-bit activations for the write-back buffer.
- Fully pipelined, valid/ready on both sides, one beat per cycle when not stalled.

---
 rtl/requant_pipe.sv | 187 ++++++++++++++++++
 tb/tb_requant_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_pipe.sv
// requant_pipe: 4-stage bias / scale / rounding-shift / zero-point requantiser for LANES accumulator sums.
// Optional build macro QUANT_RELU_EN: the low clamp becomes the zero point (fused ReLU).
module requant_pipe #(
  parameter int LANES   = 8,
  parameter int ACC_W   = 32,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 6,
  parameter int OUT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*ACC_W-1:0] s_data,
  input  logic                   s_last,
  input  logic                   param_wr,
  input  logic [ACC_W-1:0]       param_bias,
  input  logic [MULT_W-1:0]      param_mult,
  input  logic [SHIFT_W-1:0]     param_shift,
  input  logic [OUT_W-1:0]       param_zp,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*OUT_W-1:0] m_data,
  output logic                   m_last,
  output logic [15:0]            sat_cnt
);
  localparam int PW = ACC_W + MULT_W;
  localparam int RW = PW + 1;
  localparam int VW = RW + 1;
  localparam int CW = $clog2(LANES + 1);
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                 adv;
  logic [ACC_W-1:0]     bias_r;
  logic [MULT_W-1:0]    mult_r;
  logic [SHIFT_W-1:0]   shift_r;
  logic [OUT_W-1:0]     zp_r;

  logic                 v1, v2, v3, last1, last2, last3;
  logic [MULT_W-1:0]    mult1;
  logic [SHIFT_W-1:0]   shift1, shift2;
  logic [OUT_W-1:0]     zp1, zp2, zp3;
  logic signed [ACC_W-1:0] sum1 [LANES];
  logic signed [ACC_W-1:0] sum_c [LANES];
  logic signed [PW-1:0] prod2 [LANES];
  logic signed [PW-1:0] prod_c [LANES];
  logic signed [RW-1:0] r3 [LANES];
  logic signed [RW-1:0] r_c [LANES];

  logic signed [ACC_W:0] wide;
  logic signed [PW-1:0]  acc_ext, mult_ext;
  logic signed [RW-1:0]  pe, rnd;
  logic signed [VW-1:0]  v, lo, hi, zp_ext;
  logic [LANES*OUT_W-1:0] out_c;
  logic [LANES-1:0]      clip;
  logic [CW-1:0]         clip_n;
  logic [16:0]           sat_sum;

  assign adv     = !(m_valid && !m_ready);
  assign s_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_r  <= '0;
      mult_r  <= MULT_W'(1);
      shift_r <= '0;
      zp_r    <= '0;
    end else if (param_wr) begin
      bias_r  <= param_bias;
      mult_r  <= param_mult;
      shift_r <= param_shift;
      zp_r    <= param_zp;
    end
  end

  // S1: bias add in ACC_W+1 bits, then saturate back to the signed accumulator range
  always_comb begin
    wide = '0;
    for (int i = 0; i < LANES; i++) begin
      wide = $signed({s_data[i*ACC_W + ACC_W - 1], s_data[i*ACC_W +: ACC_W]})
           + $signed({bias_r[ACC_W-1], bias_r});
      if (wide[ACC_W] != wide[ACC_W-1])
        sum_c[i] = wide[ACC_W] ? SMIN : SMAX;
      else
        sum_c[i] = wide[ACC_W-1:0];
    end
  end

  always_comb begin
    acc_ext  = '0;
    mult_ext = {{(PW-MULT_W){1'b0}}, mult1};
    for (int i = 0; i < LANES; i++) begin
      acc_ext   = {{(PW-ACC_W){sum1[i][ACC_W-1]}}, sum1[i]};
      prod_c[i] = acc_ext * mult_ext;
    end
  end

  // S3: one extra bit so adding the half-LSB never wraps; shift=0 leaves rnd at zero
  always_comb begin
    pe  = '0;
    rnd = '0;
    if (shift2 != '0)
      rnd = RW'(1) << (shift2 - SHIFT_W'(1));
    for (int i = 0; i < LANES; i++) begin
      pe     = {prod2[i][PW-1], prod2[i]};
      r_c[i] = (pe + rnd) >>> shift2;
    end
  end

  always_comb begin
    out_c  = '0;
    clip   = '0;
    v      = '0;
    zp_ext = {{(VW-OUT_W){1'b0}}, zp3};
    hi     = {{(VW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
`ifdef QUANT_RELU_EN
    lo     = zp_ext;
`else
    lo     = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      v = {r3[i][RW-1], r3[i]} + zp_ext;
      if (v < lo) begin
        out_c[i*OUT_W +: OUT_W] = lo[OUT_W-1:0];
        clip[i] = 1'b1;
      end else if (v > hi) begin
        out_c[i*OUT_W +: OUT_W] = {OUT_W{1'b1}};
        clip[i] = 1'b1;
      end else begin
        out_c[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
    end
  end

  always_comb begin
    clip_n = '0;
    for (int i = 0; i < LANES; i++)
      clip_n = clip_n + CW'(clip[i]);
  end

  assign sat_sum = {1'b0, sat_cnt} + 17'(clip_n);

  // Valid/last/output state; everything holds while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      last1   <= 1'b0;
      last2   <= 1'b0;
      last3   <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
      sat_cnt <= '0;
    end else if (adv) begin
      v1      <= s_valid;
      last1   <= s_valid && s_last;
      v2      <= v1;
      last2   <= last1;
      v3      <= v2;
      last3   <= last2;
      m_valid <= v3;
      m_last  <= last3;
      if (v3) begin
        m_data  <= out_c;
        sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end

  // Datapath plus per-beat parameter snapshots; qualified by the valid bits above
  always_ff @(posedge clk) begin
    if (adv) begin
      sum1   <= sum_c;
      mult1  <= mult_r;
      shift1 <= shift_r;
      zp1    <= zp_r;
      prod2  <= prod_c;
      shift2 <= shift1;
      zp2    <= zp1;
      r3     <= r_c;
      zp3    <= zp2;
    end
  end
endmodule

// File: tb/tb_requant_pipe.sv
// tb_requant_pipe: directed self-checking bench for requant_pipe (8 lanes, 32-bit acc, 8-bit out).
// Expected values are hand-derived; QUANT_RELU_EN selects the fused-ReLU expectations.
module tb_requant_pipe;
  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [255:0] s_data;
  logic         param_wr;
  logic [31:0]  param_bias;
  logic [15:0]  param_mult;
  logic [5:0]   param_shift;
  logic [7:0]   param_zp;
  logic         m_valid, m_ready, m_last;
  logic [63:0]  m_data;
  logic [15:0]  sat_cnt;

  int checks  = 0;
  int fails   = 0;
  int exp_sat = 0;

  always #5 clk = ~clk;

  requant_pipe dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .param_wr(param_wr), .param_bias(param_bias), .param_mult(param_mult),
    .param_shift(param_shift), .param_zp(param_zp),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sat_cnt(sat_cnt)
  );

  function automatic logic [255:0] pack_acc(input int vals[8]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = vals[i];
    return r;
  endfunction

  function automatic logic [63:0] pack_out(input int vals[8]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(vals[i]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input int bias, input int mult, input int shift, input int zp);
    param_wr    = 1'b1;
    param_bias  = bias;
    param_mult  = 16'(mult);
    param_shift = 6'(shift);
    param_zp    = 8'(zp);
    step();
    param_wr    = 1'b0;
  endtask

  // Presents one beat for one cycle, then waits until it has reached the output register
  task automatic send_one(input int vals[8], input logic last);
    s_data  = pack_acc(vals);
    s_last  = last;
    s_valid = 1'b1;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    param_wr = 1'b0; param_bias = '0; param_mult = '0; param_shift = '0; param_zp = '0;
    step(); step();
    rst = 1'b0;
    exp_sat = 0;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 64'h0) begin fails++; $display("[TB] FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if (m_last !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (sat_cnt !== 16'h0) begin fails++; $display("[TB] FAIL reset_sat_cnt: got %0d want 0", sat_cnt); end
    checks++; if (s_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_identity();
    int vals[8] = '{0, 1, 100, 255, 256, -1, -300, 7};
    int outs[8] = '{0, 1, 100, 255, 255, 0, 0, 7};
    s_data = pack_acc(vals); s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    step(); step();
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL identity_early_valid: got %b want 0", m_valid); end
    step();
    exp_sat += 3;
    checks++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL identity_latency: got %b want 1", m_valid); end
    checks++; if (m_data !== pack_out(outs)) begin fails++; $display("[TB] FAIL identity_data: got %h want %h", m_data, pack_out(outs)); end
    checks++; if (m_last !== 1'b1) begin fails++; $display("[TB] FAIL identity_last: got %b want 1", m_last); end
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL identity_sat: got %0d want %0d", sat_cnt, exp_sat); end
    step();
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL identity_single_beat: got %b want 0", m_valid); end
  endtask

  task automatic test_scaling();
    int vals[8] = '{5, -15, 0, -20000, 100000, -12, -8, 1000};
    int outs[8] = '{139, 124, 136, 0, 255, 127, 130, 255};
    set_params(10, 3, 2, 128);
    send_one(vals, 1'b0);
    exp_sat += 3;
    checks++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL scaling_valid: got %b want 1", m_valid); end
    checks++; if (m_data !== pack_out(outs)) begin fails++; $display("[TB] FAIL scaling_data: got %h want %h", m_data, pack_out(outs)); end
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL scaling_sat: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  // Bias saturation at +max, half-LSB ties on both signs at shift=31
  task automatic test_boundary();
    int vals[8] = '{32'h7FFFFFFF, 0, 32'h3FFFFFF6, -1073741834, (-2147483647 - 1), 0, 0, 0};
    int outs[8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    set_params(10, 1, 31, 0);
    send_one(vals, 1'b0);
    exp_sat += 1;
    checks++; if (m_data !== pack_out(outs)) begin fails++; $display("[TB] FAIL boundary_data: got %h want %h", m_data, pack_out(outs)); end
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL boundary_sat: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_param_inflight();
    int v50[8]  = '{50, 50, 50, 50, 50, 50, 50, 50};
    int o50[8]  = '{50, 50, 50, 50, 50, 50, 50, 50};
    int o100[8] = '{100, 100, 100, 100, 100, 100, 100, 100};
    set_params(0, 1, 0, 0);
    m_ready = 1'b1; s_data = pack_acc(v50); s_last = 1'b0;
    s_valid = 1'b1;
    step();
    param_wr = 1'b1; param_mult = 16'd2;
    step();
    param_wr = 1'b0;
    step();
    s_valid = 1'b0;
    param_wr = 1'b1; param_mult = 16'd3;
    step();
    param_wr = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_data !== pack_out(o50)) begin fails++; $display("[TB] FAIL inflight_beat_a: got v=%b %h want v=1 %h", m_valid, m_data, pack_out(o50)); end
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== pack_out(o50)) begin fails++; $display("[TB] FAIL inflight_same_cycle_old: got v=%b %h want v=1 %h", m_valid, m_data, pack_out(o50)); end
    step();
    checks++; if (m_valid !== 1'b1 || m_data !== pack_out(o100)) begin fails++; $display("[TB] FAIL inflight_beat_b: got v=%b %h want v=1 %h", m_valid, m_data, pack_out(o100)); end
    step();
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL inflight_drain: got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    int vals[8];
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    logic       held = 1'b0;
    logic [63:0] held_data = '0;
    logic [3:0] pat = 4'b1001;
    set_params(0, 1, 0, 0);
    while (recv < 16 && cyc < 200) begin
      m_ready = pat[cyc % 4];
      s_valid = (sent < 16);
      for (int i = 0; i < 8; i++) vals[i] = sent * 8 + i;
      s_data = pack_acc(vals);
      s_last = (sent == 15);
      #1;
      checks++;
      if (s_ready !== !(m_valid && !m_ready)) begin fails++; $display("[TB] FAIL bp_s_ready: got %b want %b (cycle %0d)", s_ready, !(m_valid && !m_ready), cyc); end
      if (held) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held_data) begin fails++; $display("[TB] FAIL bp_hold: got v=%b %h want v=1 %h", m_valid, m_data, held_data); end
      end
      if (m_valid && m_ready) begin
        for (int i = 0; i < 8; i++) vals[i] = recv * 8 + i;
        checks++;
        if (m_data !== pack_out(vals)) begin fails++; $display("[TB] FAIL bp_data: beat %0d got %h want %h", recv, m_data, pack_out(vals)); end
        checks++;
        if (m_last !== (recv == 15)) begin fails++; $display("[TB] FAIL bp_last: beat %0d got %b want %b", recv, m_last, (recv == 15)); end
        recv++;
      end
      held      = m_valid && !m_ready;
      held_data = m_data;
      if (s_valid && s_ready) sent++;
      step();
      cyc++;
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    checks++; if (recv != 16) begin fails++; $display("[TB] FAIL bp_count: got %0d beats want 16", recv); end
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL bp_sat: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_relu();
    int vals[8] = '{-200, -100, 10, 200, 0, -128, -129, 127};
`ifdef QUANT_RELU_EN
    int outs[8] = '{128, 128, 138, 255, 128, 128, 128, 255};
    int clips   = 5;
`else
    int outs[8] = '{0, 28, 138, 255, 128, 0, 0, 255};
    int clips   = 3;
`endif
    set_params(0, 1, 0, 128);
    send_one(vals, 1'b0);
    exp_sat += clips;
    checks++; if (m_data !== pack_out(outs)) begin fails++; $display("[TB] FAIL relu_data: got %h want %h", m_data, pack_out(outs)); end
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL relu_sat: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_reset_midstream();
    int big[8]  = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    int vals[8] = '{0, 1, 100, 255, 256, -1, -300, 7};
    int outs[8] = '{0, 1, 100, 255, 255, 0, 0, 7};
    int stale   = 0;
    set_params(5, 2, 1, 3);
    m_ready = 1'b1; s_data = pack_acc(big); s_last = 1'b1; s_valid = 1'b1;
    repeat (3) step();
    s_valid = 1'b0; s_last = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_sat = 0;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_valid: got %b want 0", m_valid); end
    checks++; if (sat_cnt !== 16'h0) begin fails++; $display("[TB] FAIL midrst_sat: got %0d want 0", sat_cnt); end
    checks++; if (m_data !== 64'h0 || m_last !== 1'b0) begin fails++; $display("[TB] FAIL midrst_outputs: got %h last=%b want 0 last=0", m_data, m_last); end
    repeat (6) begin
      step();
      if (m_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin fails++; $display("[TB] FAIL midrst_stale: got %0d valid cycles want 0", stale); end
    send_one(vals, 1'b0);
    exp_sat += 3;
    checks++; if (m_data !== pack_out(outs)) begin fails++; $display("[TB] FAIL midrst_default_params: got %h want %h", m_data, pack_out(outs)); end
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL midrst_sat_after: got %0d want %0d", sat_cnt, exp_sat); end
  endtask

  task automatic test_sat_saturate();
    int big[8] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    set_params(0, 1, 0, 0);
    m_ready = 1'b1; s_data = pack_acc(big); s_last = 1'b0; s_valid = 1'b1;
    repeat (100) step();
    s_valid = 1'b0;
    repeat (5) step();
    exp_sat += 800;
    checks++; if (sat_cnt !== 16'(exp_sat)) begin fails++; $display("[TB] FAIL satcnt_stream: got %0d want %0d", sat_cnt, exp_sat); end
    s_valid = 1'b1;
    repeat (8200) step();
    s_valid = 1'b0;
    repeat (5) step();
    checks++; if (sat_cnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL satcnt_ceiling: got %h want ffff", sat_cnt); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL satcnt_drain: got %b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scaling();
    test_boundary();
    test_param_inflight();
    test_backpressure();
    test_relu();
    test_reset_midstream();
    test_sat_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
